// File: rtl/regfile.sv
// regfile: 2^ADDR_W x DATA_W register file, r0 hard-wired to zero, two combinational read ports,
// 1-cycle write commit, 32-bit retired-write counter. Asynchronous active-high reset clears all state.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through forwarding to the read ports.
// Without it (default build), reads always show stored state.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [31:0]       wr_count
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [31:0]       wr_count_q;
  logic [31:0]       wr_count_d;
  logic              commit;

  // A write retires only when enabled and aimed at a real register (r0 writes are dropped)
  assign commit = we && (waddr != '0);

  // Next-state for storage and the retired-write counter
  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (commit) begin
      regs_d[waddr] = wdata;
      wr_count_d    = wr_count_q + 32'd1;
    end
    regs_d[0] = '0;
  end

  // State registers; reset wins over any write in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Read port 1: gated by enable, r0 and reset; optional forwarding of the in-flight write
  always_comb begin
    rdata1 = '0;
    if (!rst && re1 && (raddr1 != '0)) begin
      rdata1 = regs_q[raddr1];
`ifdef REGFILE_BYPASS_EN
      if (commit && (waddr == raddr1)) begin
        rdata1 = wdata;
      end
`endif
    end
  end

  // Read port 2: identical behaviour to port 1
  always_comb begin
    rdata2 = '0;
    if (!rst && re2 && (raddr2 != '0)) begin
      rdata2 = regs_q[raddr2];
`ifdef REGFILE_BYPASS_EN
      if (commit && (waddr == raddr2)) begin
        rdata2 = wdata;
      end
`endif
    end
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: expected values are queued as stimulus is driven
// and popped/compared against the DUT outputs at each sample point.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] wr_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          sel;   // 0 = rdata1, 1 = rdata2, 2 = wr_count
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Pop every queued expectation and compare with the live outputs
  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       obs = rdata1;
        1:       obs = rdata2;
        default: obs = wr_count;
      endcase
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance to 1 time unit past the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    rd(1'b1, 5'd5, 1'b1, 5'd5);

    // Reset state
    step();
    push("reset_rdata1", 0, 32'h0);
    push("reset_rdata2", 1, 32'h0);
    push("reset_wr_count", 2, 32'h0);
    drain();
    rst = 1'b0;

    // Write r5 then assert reset mid-cycle
    wr(5'd5, 32'hDEAD_BEEF);
    step();
    we = 1'b0;
    #1;
    push("r5_before_reset", 0, 32'hDEAD_BEEF);
    push("count_before_reset", 2, 32'd1);
    drain();
    #1 rst = 1'b1;
    #1;
    push("r5_async_reset_p1", 0, 32'h0);
    push("r5_async_reset_p2", 1, 32'h0);
    push("count_async_reset", 2, 32'h0);
    drain();
    // Write attempted while reset held is ignored
    wr(5'd5, 32'h5555_5555);
    step();
    we = 1'b0;
    push("rdata1_held_reset", 0, 32'h0);
    push("count_held_reset", 2, 32'h0);
    drain();
    rst = 1'b0;
    #1;
    push("r5_after_release", 0, 32'h0);
    push("count_after_release", 2, 32'h0);
    drain();

    // Basic write/read on r7
    wr(5'd7, 32'h1234_5678);
    step();
    we = 1'b0;
    rd(1'b1, 5'd7, 1'b1, 5'd7);
    #1;
    push("r7_p1", 0, 32'h1234_5678);
    push("r7_p2", 1, 32'h1234_5678);
    push("count_r7", 2, 32'd1);
    drain();

    // r0 protection
    wr(5'd0, 32'hFFFF_FFFF);
    rd(1'b1, 5'd0, 1'b1, 5'd0);
    step();
    we = 1'b0;
    #1;
    push("r0_p1", 0, 32'h0);
    push("r0_p2", 1, 32'h0);
    push("count_r0", 2, 32'd1);
    drain();

    // Same-cycle hazard on r3
    wr(5'd3, 32'h0000_0011);
    step();
    wr(5'd3, 32'h0000_0022);
    rd(1'b1, 5'd3, 1'b1, 5'd3);
    #1;
`ifdef REGFILE_BYPASS_EN
    push("hazard_same_p1", 0, 32'h0000_0022);
    push("hazard_same_p2", 1, 32'h0000_0022);
`else
    push("hazard_same_p1", 0, 32'h0000_0011);
    push("hazard_same_p2", 1, 32'h0000_0011);
`endif
    drain();
    step();
    we = 1'b0;
    #1;
    push("hazard_next_p1", 0, 32'h0000_0022);
    push("hazard_next_p2", 1, 32'h0000_0022);
    push("count_hazard", 2, 32'd3);
    drain();

    // Read-enable gating on r9
    wr(5'd9, 32'hA5A5_A5A5);
    step();
    we = 1'b0;
    rd(1'b0, 5'd9, 1'b1, 5'd9);
    #1;
    push("gate_re1_off", 0, 32'h0);
    push("gate_re2_on", 1, 32'hA5A5_A5A5);
    push("count_gate", 2, 32'd4);
    drain();

    // Counter wrap
    force dut.wr_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.wr_count_q;
    #1;
    push("count_forced", 2, 32'hFFFF_FFFE);
    drain();
    rd(1'b1, 5'd1, 1'b1, 5'd1);
    for (int i = 1; i <= 3; i++) begin
      wr(5'd1, 32'h0000_0100 + 32'(i));
      step();
      push("wrap_count", 2, 32'hFFFF_FFFE + 32'(i));
      drain();
    end
    we = 1'b0;
    #1;
    push("wrap_r1_p1", 0, 32'h0000_0103);
    push("wrap_r1_p2", 1, 32'h0000_0103);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
